// File: rtl/rs_issue_scheduler_if.sv
// Dispatch / issue / wakeup bundle for the reservation-station issue scheduler.
// The master side is the rename/dispatch stage; the slave side is the scheduler.
interface rs_issue_scheduler_if;
  // dispatch slot 1
  logic       disp_valid_1;
  logic [6:0] disp_op_1;
  logic [5:0] disp_pd_1;
  logic [5:0] disp_ps1_1;
  logic [5:0] disp_ps2_1;
  logic       disp_r1_1;
  logic       disp_r2_1;
  logic       disp_mul_1;
  logic [3:0] disp_rob_1;
  // dispatch slot 2
  logic       disp_valid_2;
  logic [6:0] disp_op_2;
  logic [5:0] disp_pd_2;
  logic [5:0] disp_ps1_2;
  logic [5:0] disp_ps2_2;
  logic       disp_r1_2;
  logic       disp_r2_2;
  logic       disp_mul_2;
  logic [3:0] disp_rob_2;
  // control and status
  logic       disp_ready;
  logic [3:0] rob_head;
  logic       flush;
  logic [4:0] free_count;
  // issue ports: FU0/FU1 are ALU, FU2 is MUL
  logic       issue_valid_0, issue_valid_1, issue_valid_2;
  logic [6:0] issue_op_0, issue_op_1, issue_op_2;
  logic [5:0] issue_pd_0, issue_pd_1, issue_pd_2;
  logic [5:0] issue_ps1_0, issue_ps1_1, issue_ps1_2;
  logic [5:0] issue_ps2_0, issue_ps2_1, issue_ps2_2;
  logic [3:0] issue_rob_0, issue_rob_1, issue_rob_2;
  // wakeups
  logic       wake_valid_0, wake_valid_1, wake_valid_2;
  logic [5:0] wake_pd_0, wake_pd_1, wake_pd_2;
  logic       ext_wake_valid;
  logic [5:0] ext_wake_pd;

  modport master (
    output disp_valid_1, disp_op_1, disp_pd_1, disp_ps1_1, disp_ps2_1,
           disp_r1_1, disp_r2_1, disp_mul_1, disp_rob_1,
           disp_valid_2, disp_op_2, disp_pd_2, disp_ps1_2, disp_ps2_2,
           disp_r1_2, disp_r2_2, disp_mul_2, disp_rob_2,
           rob_head, flush, ext_wake_valid, ext_wake_pd,
    input  disp_ready, free_count,
           issue_valid_0, issue_valid_1, issue_valid_2,
           issue_op_0, issue_op_1, issue_op_2,
           issue_pd_0, issue_pd_1, issue_pd_2,
           issue_ps1_0, issue_ps1_1, issue_ps1_2,
           issue_ps2_0, issue_ps2_1, issue_ps2_2,
           issue_rob_0, issue_rob_1, issue_rob_2,
           wake_valid_0, wake_valid_1, wake_valid_2,
           wake_pd_0, wake_pd_1, wake_pd_2
  );

  modport slave (
    input  disp_valid_1, disp_op_1, disp_pd_1, disp_ps1_1, disp_ps2_1,
           disp_r1_1, disp_r2_1, disp_mul_1, disp_rob_1,
           disp_valid_2, disp_op_2, disp_pd_2, disp_ps1_2, disp_ps2_2,
           disp_r1_2, disp_r2_2, disp_mul_2, disp_rob_2,
           rob_head, flush, ext_wake_valid, ext_wake_pd,
    output disp_ready, free_count,
           issue_valid_0, issue_valid_1, issue_valid_2,
           issue_op_0, issue_op_1, issue_op_2,
           issue_pd_0, issue_pd_1, issue_pd_2,
           issue_ps1_0, issue_ps1_1, issue_ps1_2,
           issue_ps2_0, issue_ps2_1, issue_ps2_2,
           issue_rob_0, issue_rob_1, issue_rob_2,
           wake_valid_0, wake_valid_1, wake_valid_2,
           wake_pd_0, wake_pd_1, wake_pd_2
  );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Unified reservation station with two ALU issue ports and one pipelined
// MUL port. Selection is oldest-first by ROB age; ALU results wake their
// dependents in the issue cycle, MUL results after a latency counter expires.
module rs_issue_scheduler #(
  parameter int NUM_RS  = 16,
  parameter int MUL_LAT = 3
) (
  input logic                 clk,
  input logic                 rst,
  rs_issue_scheduler_if.slave bus
);
  localparam int IW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [NUM_RS-1:0] in_use, r1, r2, is_mul;
  logic [6:0] row_op  [NUM_RS];
  logic [5:0] row_pd  [NUM_RS];
  logic [5:0] row_ps1 [NUM_RS];
  logic [5:0] row_ps2 [NUM_RS];
  logic [3:0] row_rob [NUM_RS];

  logic [4:0] free_q;
  logic [2:0] mul_cnt;
  logic [5:0] mul_pd;
  logic       wake2_v;
  logic [5:0] wake2_pd;

  logic       iss_v   [3];
  logic [6:0] iss_op  [3];
  logic [5:0] iss_pd  [3];
  logic [5:0] iss_ps1 [3];
  logic [5:0] iss_ps2 [3];
  logic [3:0] iss_rob [3];

  // Both dispatch slots viewed as a two-entry array
  logic       d_valid [2];
  logic [6:0] d_op    [2];
  logic [5:0] d_pd    [2];
  logic [5:0] d_ps1   [2];
  logic [5:0] d_ps2   [2];
  logic       d_r1    [2];
  logic       d_r2    [2];
  logic       d_mul   [2];
  logic [3:0] d_rob   [2];

  assign d_valid[0] = bus.disp_valid_1;  assign d_valid[1] = bus.disp_valid_2;
  assign d_op[0]    = bus.disp_op_1;     assign d_op[1]    = bus.disp_op_2;
  assign d_pd[0]    = bus.disp_pd_1;     assign d_pd[1]    = bus.disp_pd_2;
  assign d_ps1[0]   = bus.disp_ps1_1;    assign d_ps1[1]   = bus.disp_ps1_2;
  assign d_ps2[0]   = bus.disp_ps2_1;    assign d_ps2[1]   = bus.disp_ps2_2;
  assign d_r1[0]    = bus.disp_r1_1;     assign d_r1[1]    = bus.disp_r1_2;
  assign d_r2[0]    = bus.disp_r2_1;     assign d_r2[1]    = bus.disp_r2_2;
  assign d_mul[0]   = bus.disp_mul_1;    assign d_mul[1]   = bus.disp_mul_2;
  assign d_rob[0]   = bus.disp_rob_1;    assign d_rob[1]   = bus.disp_rob_2;

  // Every wakeup visible this cycle: two ALU issues, the MUL result, external
  logic       wv [4];
  logic [5:0] wp [4];
  assign wv[0] = iss_v[0];           assign wp[0] = iss_pd[0];
  assign wv[1] = iss_v[1];           assign wp[1] = iss_pd[1];
  assign wv[2] = wake2_v;            assign wp[2] = wake2_pd;
  assign wv[3] = bus.ext_wake_valid; assign wp[3] = bus.ext_wake_pd;

  logic [NUM_RS-1:0] rdy1, rdy2, elig;
  logic [3:0]        age [NUM_RS];
  logic              d_rdy1 [2];
  logic              d_rdy2 [2];

  // Source readiness including same-cycle wakeup bypass, plus per-row ROB age
  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      rdy1[i] = r1[i];
      rdy2[i] = r2[i];
      for (int w = 0; w < 4; w++) begin
        if (wv[w] && wp[w] == row_ps1[i]) rdy1[i] = 1'b1;
        if (wv[w] && wp[w] == row_ps2[i]) rdy2[i] = 1'b1;
      end
      elig[i] = in_use[i] & rdy1[i] & rdy2[i];
      age[i]  = row_rob[i] - bus.rob_head;
    end
    for (int k = 0; k < 2; k++) begin
      d_rdy1[k] = d_r1[k] || (d_ps1[k] == 6'd0);
      d_rdy2[k] = d_r2[k] || (d_ps2[k] == 6'd0);
      for (int w = 0; w < 4; w++) begin
        if (wv[w] && wp[w] == d_ps1[k]) d_rdy1[k] = 1'b1;
        if (wv[w] && wp[w] == d_ps2[k]) d_rdy2[k] = 1'b1;
      end
    end
  end

  logic              sel_v   [3];
  logic [IW-1:0]     sel_idx [3];
  logic [3:0]        sel_age [3];
  logic [NUM_RS-1:0] issue_mask;

  // Oldest and second-oldest eligible ALU rows, oldest MUL row when the unit is free
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      sel_v[n]   = 1'b0;
      sel_idx[n] = '0;
      sel_age[n] = '0;
    end
    for (int i = 0; i < NUM_RS; i++) begin
      if (elig[i] && !is_mul[i] && (!sel_v[0] || age[i] < sel_age[0])) begin
        sel_v[0] = 1'b1; sel_idx[0] = IW'(i); sel_age[0] = age[i];
      end
    end
    for (int i = 0; i < NUM_RS; i++) begin
      if (elig[i] && !is_mul[i] && !(sel_v[0] && sel_idx[0] == IW'(i)) &&
          (!sel_v[1] || age[i] < sel_age[1])) begin
        sel_v[1] = 1'b1; sel_idx[1] = IW'(i); sel_age[1] = age[i];
      end
    end
    for (int i = 0; i < NUM_RS; i++) begin
      if (mul_cnt == 3'd0 && elig[i] && is_mul[i] && (!sel_v[2] || age[i] < sel_age[2])) begin
        sel_v[2] = 1'b1; sel_idx[2] = IW'(i); sel_age[2] = age[i];
      end
    end
    issue_mask = '0;
    for (int n = 0; n < 3; n++)
      if (sel_v[n]) issue_mask[sel_idx[n]] = 1'b1;
  end

  logic              accept    [2];
  logic [IW-1:0]     alloc_idx [2];
  logic [NUM_RS-1:0] taken;
  logic              found;
  logic [1:0]        n_disp, n_iss;

  assign bus.disp_ready = (free_q >= 5'd2);
  assign accept[0] = d_valid[0] && bus.disp_ready && !bus.flush;
  assign accept[1] = d_valid[1] && bus.disp_ready && !bus.flush;

  // Lowest free rows for the accepted slots (slot 1 first) and the count deltas
  always_comb begin
    taken = '0;
    found = 1'b0;
    for (int k = 0; k < 2; k++) begin
      alloc_idx[k] = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_RS; i++) begin
        if (accept[k] && !found && !in_use[i] && !taken[i]) begin
          found        = 1'b1;
          alloc_idx[k] = IW'(i);
          taken[i]     = 1'b1;
        end
      end
    end
    n_disp = 2'(accept[0]) + 2'(accept[1]);
    n_iss  = 2'(sel_v[0]) + 2'(sel_v[1]) + 2'(sel_v[2]);
  end

  // Free-row counter tracks dispatches out and issues back in
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           free_q <= 5'(NUM_RS);
    else if (bus.flush) free_q <= 5'(NUM_RS);
    else               free_q <= free_q - 5'(n_disp) + 5'(n_iss);
  end

  // Row occupancy and ready bits: clear issued rows, absorb wakeups, fill new rows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_use <= '0;
      r1     <= '0;
      r2     <= '0;
      is_mul <= '0;
    end else if (bus.flush) begin
      in_use <= '0;
    end else begin
      in_use <= in_use & ~issue_mask;
      r1     <= rdy1;
      r2     <= rdy2;
      for (int k = 0; k < 2; k++) begin
        if (accept[k]) begin
          in_use[alloc_idx[k]] <= 1'b1;
          r1[alloc_idx[k]]     <= d_rdy1[k];
          r2[alloc_idx[k]]     <= d_rdy2[k];
          is_mul[alloc_idx[k]] <= d_mul[k];
        end
      end
    end
  end

  // Row payload is only meaningful while in_use, so it needs no reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (accept[k]) begin
        row_op[alloc_idx[k]]  <= d_op[k];
        row_pd[alloc_idx[k]]  <= d_pd[k];
        row_ps1[alloc_idx[k]] <= d_ps1[k];
        row_ps2[alloc_idx[k]] <= d_ps2[k];
        row_rob[alloc_idx[k]] <= d_rob[k];
      end
    end
  end

  // Issue registers, MUL latency counter and the delayed MUL wakeup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 3; n++) begin
        iss_v[n] <= 1'b0;   iss_op[n]  <= '0; iss_pd[n]  <= '0;
        iss_ps1[n] <= '0;   iss_ps2[n] <= '0; iss_rob[n] <= '0;
      end
      mul_cnt <= '0; mul_pd <= '0; wake2_v <= 1'b0; wake2_pd <= '0;
    end else if (bus.flush) begin
      for (int n = 0; n < 3; n++) begin
        iss_v[n] <= 1'b0;   iss_op[n]  <= '0; iss_pd[n]  <= '0;
        iss_ps1[n] <= '0;   iss_ps2[n] <= '0; iss_rob[n] <= '0;
      end
      mul_cnt <= '0; mul_pd <= '0; wake2_v <= 1'b0; wake2_pd <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        iss_v[n]   <= sel_v[n];
        iss_op[n]  <= sel_v[n] ? row_op[sel_idx[n]]  : '0;
        iss_pd[n]  <= sel_v[n] ? row_pd[sel_idx[n]]  : '0;
        iss_ps1[n] <= sel_v[n] ? row_ps1[sel_idx[n]] : '0;
        iss_ps2[n] <= sel_v[n] ? row_ps2[sel_idx[n]] : '0;
        iss_rob[n] <= sel_v[n] ? row_rob[sel_idx[n]] : '0;
      end
      if (sel_v[2]) begin
        mul_cnt <= 3'(MUL_LAT);
        mul_pd  <= row_pd[sel_idx[2]];
      end else if (mul_cnt != 3'd0) begin
        mul_cnt <= mul_cnt - 3'd1;
      end
      wake2_v  <= (mul_cnt == 3'd1);
      wake2_pd <= (mul_cnt == 3'd1) ? mul_pd : '0;
    end
  end

  assign bus.free_count    = free_q;
  assign bus.issue_valid_0 = iss_v[0];   assign bus.issue_valid_1 = iss_v[1];   assign bus.issue_valid_2 = iss_v[2];
  assign bus.issue_op_0    = iss_op[0];  assign bus.issue_op_1    = iss_op[1];  assign bus.issue_op_2    = iss_op[2];
  assign bus.issue_pd_0    = iss_pd[0];  assign bus.issue_pd_1    = iss_pd[1];  assign bus.issue_pd_2    = iss_pd[2];
  assign bus.issue_ps1_0   = iss_ps1[0]; assign bus.issue_ps1_1   = iss_ps1[1]; assign bus.issue_ps1_2   = iss_ps1[2];
  assign bus.issue_ps2_0   = iss_ps2[0]; assign bus.issue_ps2_1   = iss_ps2[1]; assign bus.issue_ps2_2   = iss_ps2[2];
  assign bus.issue_rob_0   = iss_rob[0]; assign bus.issue_rob_1   = iss_rob[1]; assign bus.issue_rob_2   = iss_rob[2];
  assign bus.wake_valid_0  = iss_v[0];   assign bus.wake_pd_0     = iss_pd[0];
  assign bus.wake_valid_1  = iss_v[1];   assign bus.wake_pd_1     = iss_pd[1];
  assign bus.wake_valid_2  = wake2_v;    assign bus.wake_pd_2     = wake2_pd;
endmodule
